data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Responder end of the datapath's load/store interface. It is a multi-cycle data memory:
//   requests use MemRead/MemWrite, ram_addr, write_data and funct3. Completion is signalled
//   by a one-cycle mem_ready pulse. Loads are extended and stores are byte-merged per funct3.
//   A second asynchronous read port (addr_mem/display_mem) feeds the 7-segment display path.
// PARAMETERS
//   DEPTH_WORDS  32  number of 32-bit words; byte addresses 0 .. 4*DEPTH_WORDS-1
//   WAIT_STATES  2   cycles spent in WAIT between request capture and response (0..15)
// PORTS
//   clk          in   1   single clock, all state updates on rising edge
//   reset        in   1   asynchronous, active-high reset
//   MemRead      in   1   load request, sampled only in IDLE
//   MemWrite     in   1   store request, sampled only in IDLE
//   ram_addr     in   32  byte address
//   write_data   in   32  store data; the low byte/half/word is used per funct3
//   funct3       in   3   size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   read_data    out  32  extended load result, valid while mem_ready=1
//   mem_ready    out  1   one-cycle completion pulse
//   mem_error    out  1   error flag, qualified by mem_ready
//   addr_mem     in   5   display word index
//   display_mem  out  32  mem[addr_mem], combinational
// BEHAVIOUR
//   Reset (async, any state)
//     - FSM goes to IDLE; read_data=0, mem_ready=0, mem_error=0; all words cleared to 0.
//     - A pending store is dropped; nothing is committed.
//   FSM states: IDLE, WAIT, RESP.
//   IDLE
//     - If MemRead|MemWrite: latch addr, data, funct3 and op.
//       Go to WAIT with cnt=WAIT_STATES-1, or straight to RESP if WAIT_STATES=0.
//     - Otherwise stay in IDLE.
//   WAIT
//     - Decrement cnt; at cnt=0 go to RESP.
//     - Input changes are ignored; the latched copies are used.
//   Entry edge into RESP
//     - Store commit and read_data registration happen on this edge.
//   RESP
//     - mem_ready=1 for exactly one cycle, then IDLE.
//   Latency and throughput
//     - Capture in cycle 0; mem_ready is high in cycle WAIT_STATES+1.
//     - Back-to-back period is WAIT_STATES+2 cycles.
//   Error conditions (checked on latched values): error response gives mem_error=1,
//   read_data=0 and no memory change. Errors are:
//     - MemRead and MemWrite both high.
//     - Word index addr[31:2] >= DEPTH_WORDS.
//     - H/HU with addr[0]=1, or W with addr[1:0]!=0.
//     - Load funct3 in {3,6,7}; store funct3 other than {0,1,2}.
//   Load extension
//     - B/H: sign-extend the byte/half selected by addr[1:0] (little-endian).
//     - BU/HU: zero-extend.
//     - W: whole word.
//   Store merge
//     - SB writes only byte addr[1:0]; SH writes only half addr[1]; SW writes the full word.
//     - Untouched bytes are kept.
//   mem_ready and mem_error
//     - mem_ready is 0 outside RESP.
//     - mem_error is 0 whenever mem_ready=0.
//     - A store response drives read_data=0.
//   Display port
//     - display_mem=mem[addr_mem] when addr_mem<DEPTH_WORDS, else 0.
//     - It reflects a committed store in the cycle after the commit edge.
//     - It never stalls or affects the FSM.
// TESTING
//   1 Reset: assert mid-WAIT of SW 0x8=0xDEADBEEF, release, then LW 0x8 -> 0x00000000, mem_error=0.
//   2 Latency: WAIT_STATES=2, LW in cycle 0 -> mem_ready only in cycle 3; WAIT_STATES=0 -> cycle 1.
//   3 Byte merge: SW 0x4=0x11223344, SB 0x5=0xAA, LW 0x4 -> 0x1122AA44, display_mem[1]=0x1122AA44.
//   4 Extension: SH 0x12=0x8001; LH 0x12 -> 0xFFFF8001, LHU -> 0x00008001, LB 0x13 -> 0xFFFFFF80.
//   5 Errors: LW 0x6, LH 0x3, LW 0x80 (DEPTH 32), MemRead&MemWrite -> mem_error=1, read_data=0, memory unchanged.
//   6 Hold: change ram_addr during WAIT of SW 0x0=0x5 -> word 0 written, target of changed address untouched.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Load/store handshake between the datapath (master) and the data memory responder (slave).
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ram_addr;
    logic [31:0] write_data;
    logic [2:0]  funct3;
    logic [31:0] read_data;
    logic        mem_ready;
    logic        mem_error;

    modport master (
        output MemRead, MemWrite, ram_addr, write_data, funct3,
        input  read_data, mem_ready, mem_error
    );

    modport slave (
        input  MemRead, MemWrite, ram_addr, write_data, funct3,
        output read_data, mem_ready, mem_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: requests are latched in IDLE, held through WAIT_STATES wait cycles,
// and answered with a one-cycle mem_ready pulse; a second combinational port feeds the display.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_responder_if.slave bus,
    input  logic [4:0]          addr_mem,
    output logic [31:0]         display_mem
);
    localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rd_q, rd_d, wr_q, wr_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d, err_q, err_d;
    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     mem_d [DEPTH_WORDS];

    logic            req_rd_s, req_wr_s, req_err_s, entering_resp_s;
    logic [31:0]     req_addr_s, req_wdata_s, req_word_s;
    logic [2:0]      req_f3_s;
    logic [IDXW-1:0] req_idx_s;

    function automatic logic req_error(input logic rd, input logic wr,
                                       input logic [31:0] addr, input logic [2:0] f3);
        logic load_ok, store_ok, range_bad, align_bad;
        load_ok   = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        store_ok  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        range_bad = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
        align_bad = (((f3 == 3'd1) || (f3 == 3'd5)) && addr[0])
                 || ((f3 == 3'd2) && (addr[1:0] != 2'b00));
        return (rd && wr) || (rd && !load_ok) || (wr && !store_ok) || range_bad || align_bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] r;
        r = old;
        case (f3)
            3'd0:    r[{off, 3'b000} +: 8] = data[7:0];
            3'd1:    r[{off[1], 4'b0000} +: 16] = data[15:0];
            default: r = data;
        endcase
        return r;
    endfunction

    // Request view: live inputs while IDLE (zero-wait capture), latched copies afterwards
    always_comb begin
        if (state_q == ST_IDLE) begin
            req_rd_s    = bus.MemRead;
            req_wr_s    = bus.MemWrite;
            req_addr_s  = bus.ram_addr;
            req_wdata_s = bus.write_data;
            req_f3_s    = bus.funct3;
        end else begin
            req_rd_s    = rd_q;
            req_wr_s    = wr_q;
            req_addr_s  = addr_q;
            req_wdata_s = wdata_q;
            req_f3_s    = f3_q;
        end
        req_idx_s  = req_addr_s[2 +: IDXW];
        req_word_s = mem_q[req_idx_s];
        req_err_s  = req_error(req_rd_s, req_wr_s, req_addr_s, req_f3_s);
    end

    // FSM state register with latched request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
        end
    end

    // FSM next-state and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.MemRead || bus.MemWrite) begin
                    rd_d    = bus.MemRead;
                    wr_d    = bus.MemWrite;
                    addr_d  = bus.ram_addr;
                    wdata_d = bus.write_data;
                    f3_d    = bus.funct3;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: response and store commit are computed for the edge that enters RESP
    always_comb begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_d[i] = mem_q[i];
        end
        entering_resp_s = (state_d == ST_RESP) && (state_q != ST_RESP);
        ready_d = entering_resp_s;
        err_d   = entering_resp_s && req_err_s;
        rdata_d = 32'd0;
        if (entering_resp_s && !req_err_s) begin
            if (req_rd_s) begin
                rdata_d = load_extend(req_word_s, req_addr_s[1:0], req_f3_s);
            end else begin
                mem_d[req_idx_s] = store_merge(req_word_s, req_wdata_s, req_addr_s[1:0], req_f3_s);
            end
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Registered response and memory array, all cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.read_data = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_error = err_q;

    generate
        if (DEPTH_WORDS >= 32) begin : g_disp_full
            assign display_mem = mem_q[IDXW'(addr_mem)];
        end else begin : g_disp_part
            assign display_mem = (addr_mem < 5'(DEPTH_WORDS)) ? mem_q[addr_mem[IDXW-1:0]] : 32'd0;
        end
    endgenerate
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed reference model, per-cycle compare, directed pins.
module tb_data_mem_responder;
    localparam int WS    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();
    logic [4:0]  addr_mem_a, addr_mem_b;
    logic [31:0] display_a, display_b;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .addr_mem(addr_mem_a), .display_mem(display_a));
    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .addr_mem(addr_mem_b), .display_mem(display_b));

    typedef struct {
        int          due;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } req_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  mem_m [4*DEPTH];
    req_t        q [$];
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_cyc;
    int          issue_cyc;
    bit          disp_hold = 0;
    logic [4:0]  disp_sel = 5'd0;
    bit          use_wait_addr = 0;
    logic [31:0] wait_addr = 32'd0;
    logic [31:0] wait_data = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int op_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_err(input req_t r);
        int sz;
        sz = op_size(r.f3);
        if (r.rd && r.wr) return 1'b1;
        if (r.rd && !(r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (r.wr && !(r.f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if ((r.addr / 4) >= DEPTH) return 1'b1;
        if ((r.addr % sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input req_t r);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < op_size(r.f3); i++) v = v | (32'(mem_m[r.addr + i]) << (8 * i));
        if (r.f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (r.f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic void model_store(input req_t r);
        for (int i = 0; i < op_size(r.f3); i++) mem_m[r.addr + i] = r.data[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_word(input int k);
        return {mem_m[4*k+3], mem_m[4*k+2], mem_m[4*k+1], mem_m[4*k]};
    endfunction

    // Per-cycle compare of DUT A against the model
    initial begin : compare
        req_t        r;
        bit          e_err;
        logic [31:0] e_data;
        addr_mem_a = 5'd0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    r      = q.pop_front();
                    e_err  = model_err(r);
                    e_data = (e_err || !r.rd) ? 32'd0 : model_load(r);
                    chk("mem_ready", 32'(bus_a.mem_ready), 32'd1);
                    chk("mem_error", 32'(bus_a.mem_error), 32'(e_err));
                    chk("read_data", bus_a.read_data, e_data);
                    last_rdata = bus_a.read_data;
                    last_err   = bus_a.mem_error;
                    last_cyc   = cyc;
                    if (r.wr && !e_err) model_store(r);
                end else begin
                    chk("idle_ready", 32'(bus_a.mem_ready), 32'd0);
                    chk("idle_error", 32'(bus_a.mem_error), 32'd0);
                end
                chk("display_mem", display_a, model_word(int'(addr_mem_a)));
            end
            addr_mem_a = disp_hold ? disp_sel : 5'($urandom_range(0, 31));
        end
    end

    // Issue one request to DUT A at a negedge; returns at the next negedge it may issue again
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] f3);
        req_t r;
        bus_a.MemRead    = rd;
        bus_a.MemWrite   = wr;
        bus_a.ram_addr   = addr;
        bus_a.write_data = data;
        bus_a.funct3     = f3;
        last_rdata = 32'hxxxx_xxxx;
        last_err   = 1'bx;
        last_cyc   = -1;
        issue_cyc  = cyc;
        if (rd || wr) begin
            r.due = cyc + WS + 1; r.rd = rd; r.wr = wr; r.addr = addr; r.data = data; r.f3 = f3;
            q.push_back(r);
        end
        for (int k = 0; k <= WS; k++) begin
            @(negedge clk);
            bus_a.MemRead    = 1'($urandom_range(0, 1));
            bus_a.MemWrite   = 1'($urandom_range(0, 1));
            bus_a.ram_addr   = use_wait_addr ? wait_addr : $urandom;
            bus_a.write_data = use_wait_addr ? wait_data : $urandom;
            bus_a.funct3     = use_wait_addr ? 3'd2 : 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        bus_a.MemRead  = 1'b0;
        bus_a.MemWrite = 1'b0;
    endtask

    initial begin : main
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;
        bit          rd, wr;
        reset = 1'b1;
        bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0; bus_a.ram_addr = 32'd0;
        bus_a.write_data = 32'd0; bus_a.funct3 = 3'd0;
        bus_b.MemRead = 1'b0; bus_b.MemWrite = 1'b0; bus_b.ram_addr = 32'd0;
        bus_b.write_data = 32'd0; bus_b.funct3 = 3'd0;
        addr_mem_b = 5'd0;
        for (int i = 0; i < 4*DEPTH; i++) mem_m[i] = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus_a.mem_ready), 32'd0);
        chk("reset_error", 32'(bus_a.mem_error), 32'd0);
        chk("reset_rdata", bus_a.read_data, 32'd0);
        chk("reset_display", display_a, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a store's WAIT drops the store
        bus_a.MemWrite = 1'b1; bus_a.ram_addr = 32'h8; bus_a.write_data = 32'hDEAD_BEEF;
        bus_a.funct3 = 3'd2;
        @(negedge clk);
        bus_a.MemWrite = 1'b0;
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 4*DEPTH; i++) mem_m[i] = 8'd0;
        @(negedge clk);
        chk("midreset_ready", 32'(bus_a.mem_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b1, 1'b0, 32'h8, 32'd0, 3'd2);
        chk("lw8_after_reset", last_rdata, 32'h0000_0000);
        chk("lw8_error", 32'(last_err), 32'd0);
        chk("latency_ws2", 32'(last_cyc - issue_cyc), 32'd3);

        // Byte merge
        issue(1'b0, 1'b1, 32'h4, 32'h1122_3344, 3'd2);
        issue(1'b0, 1'b1, 32'h5, 32'h0000_00AA, 3'd0);
        issue(1'b1, 1'b0, 32'h4, 32'd0, 3'd2);
        chk("sb_merge", last_rdata, 32'h1122_AA44);
        disp_sel = 5'd1; disp_hold = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("display_word1", display_a, 32'h1122_AA44);
        @(negedge clk);
        disp_hold = 1'b0;

        // Sign/zero extension
        issue(1'b0, 1'b1, 32'h12, 32'h0000_8001, 3'd1);
        issue(1'b1, 1'b0, 32'h12, 32'd0, 3'd1);
        chk("lh_12", last_rdata, 32'hFFFF_8001);
        issue(1'b1, 1'b0, 32'h12, 32'd0, 3'd5);
        chk("lhu_12", last_rdata, 32'h0000_8001);
        issue(1'b1, 1'b0, 32'h13, 32'd0, 3'd0);
        chk("lb_13", last_rdata, 32'hFFFF_FF80);

        // Error responses leave memory unchanged
        issue(1'b1, 1'b0, 32'h6, 32'd0, 3'd2);
        chk("err_lw6", {last_rdata[30:0], last_err}, 32'd1);
        issue(1'b1, 1'b0, 32'h3, 32'd0, 3'd1);
        chk("err_lh3", {last_rdata[30:0], last_err}, 32'd1);
        issue(1'b1, 1'b0, 32'h80, 32'd0, 3'd2);
        chk("err_lw80", {last_rdata[30:0], last_err}, 32'd1);
        issue(1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF, 3'd2);
        chk("err_rdwr", {last_rdata[30:0], last_err}, 32'd1);
        issue(1'b1, 1'b0, 32'h4, 32'd0, 3'd2);
        chk("unchanged_after_err", last_rdata, 32'h1122_AA44);

        // Inputs changing during WAIT are ignored
        issue(1'b0, 1'b1, 32'h20, 32'h0000_0077, 3'd2);
        use_wait_addr = 1'b1; wait_addr = 32'h20; wait_data = 32'h0000_0099;
        issue(1'b0, 1'b1, 32'h0, 32'h0000_0005, 3'd2);
        use_wait_addr = 1'b0;
        issue(1'b1, 1'b0, 32'h20, 32'd0, 3'd2);
        chk("hold_untouched", last_rdata, 32'h0000_0077);
        issue(1'b1, 1'b0, 32'h0, 32'd0, 3'd2);
        chk("hold_written", last_rdata, 32'h0000_0005);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel <= 4) || (sel == 9);
            wr  = (sel >= 5);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            a = 32'($urandom_range(0, 127));
            sel = $urandom_range(0, 7);
            if (sel < 5) begin
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
                else if (f3[1:0] == 2'd1) a[0] = 1'b0;
            end else if (sel == 7) begin
                a = $urandom;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(rd, wr, a, $urandom, f3);
        end

        // Zero-wait-state instance with a 16-word array
        bus_b.MemWrite = 1'b1; bus_b.ram_addr = 32'h3C; bus_b.write_data = 32'hCAFE_F00D;
        bus_b.funct3 = 3'd2;
        #1 chk("b_ready_cycle0", 32'(bus_b.mem_ready), 32'd0);
        @(negedge clk);
        bus_b.MemWrite = 1'b0;
        chk("b_ready_cycle1", 32'(bus_b.mem_ready), 32'd1);
        chk("b_store_rdata", {bus_b.read_data[30:0], bus_b.mem_error}, 32'd0);
        addr_mem_b = 5'd15;
        @(negedge clk);
        chk("b_ready_cycle2", 32'(bus_b.mem_ready), 32'd0);
        chk("b_display15", display_b, 32'hCAFE_F00D);
        addr_mem_b = 5'd20;
        #1 chk("b_display_oob", display_b, 32'd0);
        bus_b.MemRead = 1'b1; bus_b.ram_addr = 32'h40;
        @(negedge clk);
        bus_b.MemRead = 1'b0;
        chk("b_err_lw40", {bus_b.read_data[29:0], bus_b.mem_error, bus_b.mem_ready}, 32'd3);
        @(negedge clk);
        bus_b.MemRead = 1'b1; bus_b.ram_addr = 32'h3C;
        @(negedge clk);
        bus_b.MemRead = 1'b0;
        chk("b_lw3c", bus_b.read_data, 32'hCAFE_F00D);
        chk("b_lw3c_ready", 32'(bus_b.mem_ready), 32'd1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
